// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the RV32I core.
// Adds a req/ack handshake with WAIT_STATES extra cycles in front of a
// word-organised RAM. It checks byte-enable legality and address range and
// returns full aligned words. A read sees the word as it was before that
// transaction's own write.
// Optional build macro DMEM_MMIO_CYCLE_EN: adds a free-running cycle
// counter that is readable at byte address 0x8000_0000.

module dmem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] daddr,
    input  logic [3:0]  dwe,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        ack,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int          RAM_WORDS = 1 << DEPTH_LOG2;
    // Wait counter start value; unused (and forced to zero) when WAIT_STATES is 0.
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Byte-enable legality for a given byte offset within the word.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
        logic ok;
        case (be)
            4'b0000: ok = 1'b1;
            4'b0001: ok = (off == 2'd0);
            4'b0010: ok = (off == 2'd1);
            4'b0100: ok = (off == 2'd2);
            4'b1000: ok = (off == 2'd3);
            4'b0011: ok = (off == 2'd0);
            4'b1100: ok = (off == 2'd2);
            4'b1111: ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State and latched request.
    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] wdata_q, wdata_d;

    // Registered response.
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;
    logic [31:0] rdata_q, rdata_d;

    // The access being resolved this cycle.
    logic [31:0] acc_addr_s;
    logic [3:0]  acc_be_s;
    logic [31:0] acc_wdata_s;
    logic        acc_oob_s;
    logic        acc_err_s;
    logic        mmio_hit_s;
    logic [31:0] mmio_word_s;
    logic        enter_resp_s;
    logic        ram_we_s;
    logic [DEPTH_LOG2-1:0] ram_idx_s;
    logic [31:0] ram_word_s;

    logic [31:0] mem_q [RAM_WORDS];

    // With zero wait states the RAM access happens on the capture edge itself,
    // so the live inputs are used in IDLE and the latched copies otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr_s  = daddr;
            acc_be_s    = dwe;
            acc_wdata_s = dwdata;
        end else begin
            acc_addr_s  = addr_q;
            acc_be_s    = be_q;
            acc_wdata_s = wdata_q;
        end
    end

`ifdef DMEM_MMIO_CYCLE_EN
    localparam logic [31:0] MMIO_ADDR = 32'h8000_0000;

    logic [31:0] cyc_q, cyc_d;

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
    end

    // Cycle counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign mmio_hit_s  = (acc_addr_s == MMIO_ADDR);
    assign mmio_word_s = cyc_q;
`else
    assign mmio_hit_s  = 1'b0;
    assign mmio_word_s = 32'd0;
`endif

    assign ram_idx_s  = acc_addr_s[DEPTH_LOG2+1:2];
    assign ram_word_s = mem_q[ram_idx_s];
    assign acc_oob_s  = |acc_addr_s[31:DEPTH_LOG2+2];

    // Reject illegal lane patterns and anything outside RAM or the MMIO word.
    always_comb begin
        if (!be_legal(acc_be_s, acc_addr_s[1:0])) begin
            acc_err_s = 1'b1;
        end else if (acc_oob_s && !mmio_hit_s) begin
            acc_err_s = 1'b1;
        end else begin
            acc_err_s = 1'b0;
        end
    end

    // Next-state, wait counter, request latch and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        enter_resp_s = 1'b0;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rdata_d      = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = daddr;
                    be_d    = dwe;
                    wdata_d = dwdata;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response is loaded on the edge entering RESP, so it is registered.
        if (enter_resp_s) begin
            ack_d = 1'b1;
            err_d = acc_err_s;
            if (acc_err_s) begin
                rdata_d = 32'd0;
            end else if (mmio_hit_s) begin
                rdata_d = mmio_word_s;
            end else begin
                rdata_d = ram_word_s;
            end
        end else begin
            ack_d   = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'd0;
        end
    end

    // A write commits on the edge entering RESP unless reset wins that edge.
    always_comb begin
        if (enter_resp_s && !reset && !acc_err_s && !mmio_hit_s) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Word RAM with per-byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be_s[i]) begin
                    mem_q[ram_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign drdata = rdata_q;
    assign ack    = ack_q;
    assign err    = err_q;

endmodule
